bt_uart_tx_sched: RTL and testbench
===================================

// Module: bt_uart_tx_sched
// PURPOSE
//  Shares the Bluetooth-peripheral UART transmit path between NREQ requesters with round-robin arbitration.
//  Generates the bit-period timing internally: a counter on clk_in replaces the free-running divided clock.
//  Serializes each granted byte as an 8N1 frame on tx, LSB first.
//  Sits between the BT peripheral's command/data sources and the BT module TX pin.
// PARAMETERS
//  NREQ      2     number of requesters (1..8)
//  BAUD_DIV  2602  clk_in cycles per UART bit (>=2); 2602 = 2*(1300+1)
//  DATA_W    8     fixed payload width; other values unsupported
// PORTS
//  clk_in   in   1          system clock; all state on rising edge
//  reset    in   1          asynchronous, active-low reset
//  req      in   NREQ       per-requester transmit request, level, held until grant
//  data_in  in   NREQ*8     byte of requester i on data_in[8*i+7:8*i], stable while req[i]=1
//  grant    out  NREQ       one-hot, one-cycle pulse: byte of that requester accepted
//  busy     out  1          1 while a frame (start..stop) is on tx
//  tx       out  1          serial output, idle high
// BEHAVIOUR
//  Reset (reset=0, async): tx=1, busy=0, grant=0, state=IDLE, rr pointer=0, timers/shift reg=0. Mid-frame reset aborts the frame at once with no stop bit.
//  FSM states: IDLE, START, DATA, STOP. bit_tmr counts 0..BAUD_DIV-1; "tick" = bit_tmr==BAUD_DIV-1.
//  Arbitration: winner = first i with req[i]=1, searching from rr pointer upward with wrap (NREQ-1 -> 0).
//  IDLE, any req at edge: grant[winner]<=1 for exactly one cycle; shreg<=data_in of winner.
//    Same edge: tx<=0, busy<=1, bit_tmr<=0, state<=START, rr<=(winner+1) mod NREQ.
//  IDLE, no req: outputs hold; no grant.
//  START: tx=0 for BAUD_DIV cycles. On tick: tx<=shreg[0], bit_idx<=0, state<=DATA.
//  DATA: each bit is held BAUD_DIV cycles. On tick with bit_idx<7: shift shreg right, drive the next bit, bit_idx++.
//    On tick with bit_idx==7: tx<=1, state<=STOP.
//  STOP: tx=1 for BAUD_DIV cycles. On tick:
//    - any req: same action as IDLE grant (back-to-back frame, no idle gap);
//    - otherwise busy<=0 and state<=IDLE.
//  Frame length: exactly 10*BAUD_DIV cycles from the tx falling edge to the end of the stop bit.
//  Grant latency: grant is high in the first cycle after the edge that samples req=1 in IDLE or at the STOP tick.
//  req changes outside IDLE/STOP-tick are ignored. req dropped before grant means no transmission.
//  A requester must deassert req in the cycle after its grant, or it re-enters arbitration.
//  Simultaneous requests: strict round-robin. No requester wins twice while another waits.
//  rr pointer advances only on grant.
//  data_in of non-granted requesters is never sampled.
//  All outputs are registered; tx is glitch-free.
// TESTING (sim with BAUD_DIV=4, NREQ=2)
//  1 Reset: reset=0 mid-DATA -> tx=1, busy=0, grant=0 immediately (async); after release, idle until req.
//  2 Single byte: req=01, data_in[7:0]=8'hA5 -> grant=01 for 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,1.
//    Each value lasts 4 cycles (40 total); busy falls after the stop bit.
//  3 Contention: req=11 from idle, data 8'h11/8'h22 -> grant 01 first, frame 0x11.
//    Then grant 10 at the stop tick with no gap, frame 0x22.
//  4 Fairness: req[0] re-raised right after its grant while req[1] pending -> next grant goes to 10, not 01.
//  5 Withdrawal: req=10 asserted then dropped during an ongoing frame -> no grant to 10, state returns IDLE.
//  6 Timing: check 10*BAUD_DIV cycles tx-fall to frame end and the 1-cycle grant width.
//    Repeat case 2 with BAUD_DIV=2602 for one frame.

Source files
------------

// File: rtl/bt_uart_tx_sched.sv
// Round-robin shared UART transmitter: arbitrates NREQ byte requesters and
// serialises each granted byte as an 8N1 frame, with the bit timing derived from clk_in.
module bt_uart_tx_sched #(
   parameter int NREQ     = 2,
   parameter int BAUD_DIV = 2602,
   parameter int DATA_W   = 8
) (
   input  logic                   clk_in,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] data_in,
   output logic [NREQ-1:0]        grant,
   output logic                   busy,
   output logic                   tx
);

   localparam int TMR_W = $clog2(BAUD_DIV);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q;
   logic [TMR_W-1:0]  bit_tmr_q;
   logic [IDX_W-1:0]  bit_idx_q;
   logic [DATA_W-1:0] shreg_q;
   logic [PTR_W-1:0]  rr_q;
   logic [NREQ-1:0]   grant_q;
   logic              busy_q;
   logic              tx_q;

   logic              tick;
   logic              win_vld;
   logic              load_d;
   logic [PTR_W-1:0]  cand;
   logic [PTR_W-1:0]  win_idx;
   logic [PTR_W-1:0]  rr_d;
   logic [NREQ-1:0]   win_oh;
   logic [DATA_W-1:0] win_byte;

   assign tick = (bit_tmr_q == TMR_W'(BAUD_DIV - 1));

   // Scan downward from rr+NREQ-1 to rr so the last hit is the first requester at or above rr.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = PTR_W'((int'(rr_q) + k) % NREQ);
         if (req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      win_oh   = '0;
      win_byte = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == PTR_W'(i)) begin
            win_oh[i] = 1'b1;
            win_byte  = data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   assign rr_d   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
   assign load_d = win_vld && ((state_q == IDLE) || ((state_q == STOP) && tick));

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         bit_tmr_q <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         rr_q      <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         grant_q <= '0;
         if (load_d) begin
            grant_q   <= win_oh;
            shreg_q   <= win_byte;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_tmr_q <= '0;
            state_q   <= START;
            rr_q      <= rr_d;
         end else begin
            bit_tmr_q <= ((state_q == IDLE) || tick) ? '0 : bit_tmr_q + TMR_W'(1);
            case (state_q)
               START: begin
                  if (tick) begin
                     tx_q      <= shreg_q[0];
                     bit_idx_q <= '0;
                     state_q   <= DATA;
                  end
               end
               DATA: begin
                  if (tick) begin
                     if (bit_idx_q != IDX_W'(DATA_W - 1)) begin
                        shreg_q   <= shreg_q >> 1;
                        tx_q      <= shreg_q[1];
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end
               end
               STOP: begin
                  // Reaching here on a tick means nobody is requesting, so the line goes idle.
                  if (tick) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
   assign tx    = tx_q;

endmodule

// File: tb/tb_bt_uart_tx_sched.sv
// Directed bench for bt_uart_tx_sched: a short-baud instance for the protocol cases
// and a full-rate instance for one frame at BAUD_DIV=2602.
module tb_bt_uart_tx_sched;

   localparam int NREQ = 2;
   localparam int BD   = 4;
   localparam int BDB  = 2602;

   logic            clk_in = 1'b0;
   logic            reset;
   logic [NREQ-1:0] req;
   logic [15:0]     data_in;
   logic [NREQ-1:0] grant;
   logic            busy;
   logic            tx;
   logic [NREQ-1:0] req_b;
   logic [15:0]     data_b;
   logic [NREQ-1:0] grant_b;
   logic            busy_b;
   logic            tx_b;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   bt_uart_tx_sched #(.NREQ(NREQ), .BAUD_DIV(BD), .DATA_W(8)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .req    (req),
      .data_in(data_in),
      .grant  (grant),
      .busy   (busy),
      .tx     (tx)
   );

   bt_uart_tx_sched #(.NREQ(NREQ), .BAUD_DIV(BDB), .DATA_W(8)) dut_big (
      .clk_in (clk_in),
      .reset  (reset),
      .req    (req_b),
      .data_in(data_b),
      .grant  (grant_b),
      .busy   (busy_b),
      .tx     (tx_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp);
      for (int n = 0; n < 16; n++) begin
         step();
         if (grant !== '0) break;
      end
      chk(tag, 32'(grant), 32'(exp));
   endtask

   // mode 1: re-raise req[0] one cycle after grant; mode 2: raise then withdraw req[1] mid-frame
   task automatic frame_chk(input string tag, input logic [7:0] b, input int mode);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10 * BD; i++) begin
         chk({tag, " tx"}, 32'(tx), 32'(f[i/BD]));
         chk({tag, " busy"}, 32'(busy), 32'd1);
         if (i > 0) chk({tag, " grant"}, 32'(grant), 32'd0);
         if (mode == 1 && i == 1) req[0] = 1'b1;
         if (mode == 2 && i == 8) req = 2'b10;
         if (mode == 2 && i == 30) req = 2'b00;
         step();
      end
   endtask

   initial begin
      logic [9:0] fb;
      int bad;
      reset   = 1'b0;
      req     = '0;
      data_in = '0;
      req_b   = '0;
      data_b  = '0;

      step();
      step();
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst grant", 32'(grant), 32'd0);
      chk("rst big tx", 32'(tx_b), 32'd1);
      reset = 1'b1;
      repeat (3) step();
      chk("idle tx", 32'(tx), 32'd1);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle grant", 32'(grant), 32'd0);

      // single byte 0xA5 from requester 0
      data_in = 16'h00A5;
      req     = 2'b01;
      wait_grant("c2 grant", 2'b01);
      req = 2'b00;
      frame_chk("c2", 8'hA5, 0);
      chk("c2 end busy", 32'(busy), 32'd0);
      chk("c2 end tx", 32'(tx), 32'd1);
      chk("c2 end grant", 32'(grant), 32'd0);
      repeat (3) step();
      chk("c2 idle busy", 32'(busy), 32'd0);
      chk("c2 idle grant", 32'(grant), 32'd0);

      // asynchronous reset in the middle of the data bits
      req = 2'b01;
      wait_grant("c1 grant", 2'b01);
      req = 2'b00;
      repeat (10) step();
      chk("c1 pre tx", 32'(tx), 32'd0);
      chk("c1 pre busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("c1 async tx", 32'(tx), 32'd1);
      chk("c1 async busy", 32'(busy), 32'd0);
      chk("c1 async grant", 32'(grant), 32'd0);
      step();
      reset = 1'b1;
      repeat (4) step();
      chk("c1 post tx", 32'(tx), 32'd1);
      chk("c1 post busy", 32'(busy), 32'd0);
      chk("c1 post grant", 32'(grant), 32'd0);

      // contention from idle, then fairness after requester 0 re-raises
      data_in = 16'h2211;
      req     = 2'b11;
      wait_grant("c3 grant0", 2'b01);
      req = 2'b10;
      frame_chk("c3 f11", 8'h11, 1);
      chk("c4 b2b grant", 32'(grant), 32'h2);
      chk("c4 b2b tx", 32'(tx), 32'd0);
      chk("c4 b2b busy", 32'(busy), 32'd1);
      req = 2'b01;
      frame_chk("c4 f22", 8'h22, 0);
      chk("c4 next grant", 32'(grant), 32'h1);
      chk("c4 next tx", 32'(tx), 32'd0);

      // requester 1 raises and withdraws during the frame
      req = 2'b00;
      frame_chk("c5 f11", 8'h11, 2);
      chk("c5 end grant", 32'(grant), 32'd0);
      chk("c5 end busy", 32'(busy), 32'd0);
      chk("c5 end tx", 32'(tx), 32'd1);
      repeat (4) step();
      chk("c5 idle grant", 32'(grant), 32'd0);
      chk("c5 idle busy", 32'(busy), 32'd0);

      // one full-rate frame
      data_b = 16'h00A5;
      req_b  = 2'b01;
      for (int n = 0; n < 16; n++) begin
         step();
         if (grant_b !== '0) break;
      end
      chk("c6 grant", 32'(grant_b), 32'h1);
      req_b = 2'b00;
      fb    = {1'b1, 8'hA5, 1'b0};
      for (int b = 0; b < 10; b++) begin
         bad = 0;
         for (int c = 0; c < BDB; c++) begin
            if (tx_b !== fb[b]) bad++;
            if (busy_b !== 1'b1) bad++;
            if ((b > 0 || c > 0) && grant_b !== 2'b00) bad++;
            step();
         end
         chk($sformatf("c6 bit%0d bad cycles", b), 32'(bad), 32'd0);
      end
      chk("c6 end busy", 32'(busy_b), 32'd0);
      chk("c6 end tx", 32'(tx_b), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
